// File: rtl/keystroke_pkg.sv
// Shared types and scancode-set-2 letter lookup for the PS/2 keystroke path.
// Letter codes run a=0..z=25; anything else maps to NONE_CODE.
package keystroke_pkg;

    typedef logic [4:0] letter_t;

    localparam letter_t    NONE_CODE  = 5'b11111;
    localparam logic [7:0] BRK_PREFIX = 8'hF0;
    localparam logic [7:0] EXT_PREFIX = 8'hE0;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } rxState_t;

    function automatic letter_t scancode_to_letter(input logic [7:0] code);
        letter_t letter;
        case (code)
            8'h1C:   letter = 5'd0;
            8'h32:   letter = 5'd1;
            8'h21:   letter = 5'd2;
            8'h23:   letter = 5'd3;
            8'h24:   letter = 5'd4;
            8'h2B:   letter = 5'd5;
            8'h34:   letter = 5'd6;
            8'h33:   letter = 5'd7;
            8'h43:   letter = 5'd8;
            8'h3B:   letter = 5'd9;
            8'h42:   letter = 5'd10;
            8'h4B:   letter = 5'd11;
            8'h3A:   letter = 5'd12;
            8'h31:   letter = 5'd13;
            8'h44:   letter = 5'd14;
            8'h4D:   letter = 5'd15;
            8'h15:   letter = 5'd16;
            8'h2D:   letter = 5'd17;
            8'h1B:   letter = 5'd18;
            8'h2C:   letter = 5'd19;
            8'h3C:   letter = 5'd20;
            8'h2A:   letter = 5'd21;
            8'h1D:   letter = 5'd22;
            8'h22:   letter = 5'd23;
            8'h35:   letter = 5'd24;
            8'h1A:   letter = 5'd25;
            default: letter = NONE_CODE;
        endcase
        return letter;
    endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: 2-FF sync, falling-edge detect, start/data/parity/stop FSM, mid-frame timeout.
// Latency: byte_rdy/frame_error one cycle after the deciding edge cycle. PS2_PARITY_CHECK_EN drops bad-parity bytes.
// No backpressure: byte_rdy and frame_error are single-cycle strobes.
module ps2_frame_rx
    import keystroke_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] rxByte,
    output logic       byte_rdy,
    output logic       frame_error
);

    localparam int              TO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

`ifdef PS2_PARITY_CHECK_EN
    localparam bit PARITY_CHECK = 1'b1;
`else
    localparam bit PARITY_CHECK = 1'b0;
`endif

    logic [1:0]      clkSync;
    logic [1:0]      dataSync;
    logic            clkPrev;
    logic            fallEdge;
    logic            bitIn;

    rxState_t        state, stateNext;
    logic [7:0]      shiftReg, shiftNext;
    logic [2:0]      bitCnt, bitCntNext;
    logic            parityBit, parityNext;
    logic [TO_W-1:0] toCnt;
    logic            timeout;
    logic            parityOk;
    logic            rdyNext;
    logic            errNext;

    // Synchronisers idle high so leaving reset never fakes a falling edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clkSync  <= 2'b11;
            dataSync <= 2'b11;
            clkPrev  <= 1'b1;
        end else begin
            clkSync  <= {clkSync[0], ps2_clk};
            dataSync <= {dataSync[0], ps2_data};
            clkPrev  <= clkSync[1];
        end
    end

    assign fallEdge = clkPrev & ~clkSync[1];
    assign bitIn    = dataSync[1];
    assign parityOk = ^{shiftReg, parityBit};
    assign timeout  = (state != IDLE) && !fallEdge && (toCnt == TO_LAST);
    assign rxByte   = shiftReg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            toCnt <= '0;
        end else if (fallEdge || state == IDLE) begin
            toCnt <= '0;
        end else begin
            toCnt <= toCnt + 1'b1;
        end
    end

    always_comb begin
        stateNext  = state;
        shiftNext  = shiftReg;
        bitCntNext = bitCnt;
        parityNext = parityBit;
        rdyNext    = 1'b0;
        errNext    = 1'b0;
        if (fallEdge) begin
            unique case (state)
                IDLE: begin
                    if (!bitIn) begin
                        stateNext  = DATA;
                        bitCntNext = 3'd0;
                    end else begin
                        errNext = 1'b1;
                    end
                end
                DATA: begin
                    shiftNext  = {bitIn, shiftReg[7:1]};
                    bitCntNext = bitCnt + 3'd1;
                    if (bitCnt == 3'd7) begin
                        stateNext = PARITY;
                    end
                end
                PARITY: begin
                    parityNext = bitIn;
                    stateNext  = STOP;
                end
                STOP: begin
                    stateNext = IDLE;
                    if (bitIn && (parityOk || !PARITY_CHECK)) begin
                        rdyNext = 1'b1;
                    end else begin
                        errNext = 1'b1;
                    end
                end
                default: stateNext = IDLE;
            endcase
        end
        if (timeout) begin
            stateNext = IDLE;
            errNext   = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            shiftReg    <= 8'h00;
            bitCnt      <= 3'd0;
            parityBit   <= 1'b0;
            byte_rdy    <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            state       <= stateNext;
            shiftReg    <= shiftNext;
            bitCnt      <= bitCntNext;
            parityBit   <= parityNext;
            byte_rdy    <= rdyNext;
            frame_error <= errNext;
        end
    end

endmodule

// File: rtl/ps2_keystroke_decoder.sv
// PS/2 keyboard to letter keystroke decoder (scancode set 2); build option PS2_PARITY_CHECK_EN.
// Latency: outputs registered 2 cycles after the stop-bit edge cycle (edge N, byte_rdy N+1, outputs N+2).
// No backpressure: key_valid and frame_error are single-cycle strobes.
module ps2_keystroke_decoder #(
    parameter int         TIMEOUT_CYCLES = 50000,
    parameter logic [4:0] NONE_CODE      = 5'b11111
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [4:0] keystroke,
    output logic       keyReleased,
    output logic       key_valid,
    output logic       frame_error
);

    import keystroke_pkg::*;

    logic [7:0] rxByte;
    logic       byte_rdy;
    logic       ext_flag;
    logic       brk_flag;
    letter_t    codeLetter;
    logic       isLetter;
    logic       isHeld;

    ps2_frame_rx #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_rx (
        .clk        (clk),
        .reset      (reset),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .rxByte     (rxByte),
        .byte_rdy   (byte_rdy),
        .frame_error(frame_error)
    );

    // Extended (E0-prefixed) codes never count as letters.
    always_comb begin
        codeLetter = scancode_to_letter(rxByte);
        isLetter   = (codeLetter != keystroke_pkg::NONE_CODE) && !ext_flag;
        isHeld     = !keyReleased && (codeLetter == keystroke);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ext_flag    <= 1'b0;
            brk_flag    <= 1'b0;
            keystroke   <= NONE_CODE;
            keyReleased <= 1'b1;
            key_valid   <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            if (byte_rdy) begin
                if (rxByte == EXT_PREFIX) begin
                    ext_flag <= 1'b1;
                end else if (rxByte == BRK_PREFIX) begin
                    brk_flag <= 1'b1;
                end else begin
                    ext_flag <= 1'b0;
                    brk_flag <= 1'b0;
                    if (isLetter) begin
                        if (brk_flag) begin
                            if (isHeld) begin
                                keyReleased <= 1'b1;
                                keystroke   <= NONE_CODE;
                            end
                        end else if (!isHeld) begin
                            // Typematic repeats of the held key fall through silently.
                            keystroke   <= codeLetter;
                            keyReleased <= 1'b0;
                            key_valid   <= 1'b1;
                        end
                    end
                end
            end
        end
    end

endmodule
